// File: rtl/ps2_pkg.sv
// Shared PS/2 receive types, prefix bytes and game scan codes.
// Used by ps2_scan_rx and the downstream keyboard command decoder.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_t;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

  localparam logic [7:0] KEY_A     = 8'h1C;
  localparam logic [7:0] KEY_D     = 8'h23;
  localparam logic [7:0] KEY_SPACE = 8'h29;

  // Odd parity over data plus parity bit.
  function automatic logic ps2_parity_ok(
    input logic [7:0] data,
    input logic       par
  );
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronizer, FILTER_LEN-sample glitch filter and falling-edge strobe
// for one asynchronous PS/2 line that idles high.
module ps2_line_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_line,
  output logic o_level,
  output logic o_fall
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          cnt;
  logic                   line_s;

  assign line_s = sync[SYNC_STAGES-1];

  // o_fall pulses in the same cycle o_level drops.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync    <= '1;
      cnt     <= '0;
      o_level <= 1'b1;
      o_fall  <= 1'b0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], i_line};
      o_fall <= 1'b0;
      if (line_s == o_level) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        cnt     <= '0;
        o_level <= line_s;
        o_fall  <= ~line_s;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_scan_rx.sv
// PS/2 frame receiver with E0/F0 prefix stripping, all in the i_clk domain.
// Define PS2_TYPEMATIC_FILTER_EN to suppress repeated identical make codes.
module ps2_scan_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic [7:0] o_scan_code,
  output logic       o_scan_valid,
  output logic       o_break,
  output logic       o_extended,
  output logic       o_frame_err,
  output logic       o_busy
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  ps2_state_t             state;
  logic [SYNC_STAGES-1:0] dsync;
  logic                   data_s;
  logic                   clk_lvl;
  logic                   fall;
  logic [2:0]             bit_cnt;
  logic [7:0]             shreg;
  logic                   par_bit;
  logic [TW-1:0]          tcnt;
  logic                   ext_f;
  logic                   brk_f;
  logic                   frame_ok;
  logic                   is_pfx;
  logic                   make_evt;
  logic                   brk_evt;
  logic                   rpt;
  logic                   timeout;

  ps2_line_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_clk_filt (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_line  (i_ps2_clk),
    .o_level (clk_lvl),
    .o_fall  (fall)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) dsync <= '1;
    else       dsync <= {dsync[SYNC_STAGES-2:0], i_ps2_data};
  end

  assign data_s   = dsync[SYNC_STAGES-1];
  assign frame_ok = fall && (state == STOP) && data_s &&
                    ps2_parity_ok(shreg, par_bit);
  assign is_pfx   = (shreg == PS2_PREFIX_EXT) || (shreg == PS2_PREFIX_BRK);
  assign make_evt = frame_ok && !is_pfx && !brk_f;
  assign brk_evt  = frame_ok && !is_pfx && brk_f;
  assign timeout  = (state != IDLE) && !fall && (tcnt == TW'(TIMEOUT_CYC));
  assign o_busy   = (state != IDLE);

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic [7:0] trk_code;
  logic       trk_ext;
  logic       trk_vld;

  assign rpt = trk_vld && (trk_code == shreg) && (trk_ext == ext_f);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      trk_code <= '0;
      trk_ext  <= 1'b0;
      trk_vld  <= 1'b0;
    end else if (brk_evt) begin
      trk_vld <= 1'b0;
    end else if (make_evt) begin
      trk_code <= shreg;
      trk_ext  <= ext_f;
      trk_vld  <= 1'b1;
    end
  end
`else
  assign rpt = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      shreg        <= '0;
      par_bit      <= 1'b0;
      tcnt         <= '0;
      ext_f        <= 1'b0;
      brk_f        <= 1'b0;
      o_scan_code  <= '0;
      o_scan_valid <= 1'b0;
      o_break      <= 1'b0;
      o_extended   <= 1'b0;
      o_frame_err  <= 1'b0;
    end else begin
      o_scan_valid <= 1'b0;
      o_frame_err  <= 1'b0;
      if (state == IDLE || fall) tcnt <= '0;
      else                       tcnt <= tcnt + 1'b1;

      if (timeout) begin
        state       <= IDLE;
        o_frame_err <= 1'b1;
        ext_f       <= 1'b0;
        brk_f       <= 1'b0;
      end else if (fall) begin
        unique case (state)
          IDLE: begin
            if (!data_s) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            shreg   <= {data_s, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par_bit <= data_s;
            state   <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (!frame_ok) begin
              o_frame_err <= 1'b1;
              ext_f       <= 1'b0;
              brk_f       <= 1'b0;
            end else begin
              unique case (1'b1)
                (shreg == PS2_PREFIX_EXT): ext_f <= 1'b1;
                (shreg == PS2_PREFIX_BRK): brk_f <= 1'b1;
                default: begin
                  ext_f <= 1'b0;
                  brk_f <= 1'b0;
                  if (brk_f || !rpt) begin
                    o_scan_code  <= shreg;
                    o_break      <= brk_f;
                    o_extended   <= ext_f;
                    o_scan_valid <= 1'b1;
                  end
                end
              endcase
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
